// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the multicycle MIPS datapath.
// Owns PC and IR. Runs a fixed-latency memory read on request and applies
// control-unit PC loads (branch/jump) while idle.
module fetch_unit #(
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         MEM_LATENCY = 2,
    parameter logic [DATA_W-1:0]   RESET_PC    = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_write,
    input  logic              pc_write_cond,
    input  logic              zero,
    input  logic [1:0]        pc_source,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              busy,
    output logic              fetch_done,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] ir,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [1:0]        fsm_state
);

    // Wait counter only needs to reach MEM_LATENCY-2 (max 5 for latency 7).
    localparam int unsigned       CNT_W     = 3;
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'((MEM_LATENCY >= 2) ? (MEM_LATENCY - 2) : 0);
    localparam logic [DATA_W-1:0] PC_STEP   = DATA_W'(4);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic               done_q, done_d;

    logic               pc_load_en_c;
    logic [DATA_W-1:0]  pc_load_val_c;
    logic [DATA_W-1:0]  pc_inc_c;
    logic [DATA_W-1:0]  jump_target_c;

    // PC increment wraps modulo 2^DATA_W.
    assign pc_inc_c      = pc_q + PC_STEP;
    assign jump_target_c = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};

    // Branch/jump load qualifier; only honoured in IDLE.
    assign pc_load_en_c = (state_q == S_IDLE) && (pc_write || (pc_write_cond && zero));

    // PC load source select; source 11 keeps the current PC.
    always_comb begin
        pc_load_val_c = pc_q;
        unique case (pc_source)
            2'b00:   pc_load_val_c = alu_result;
            2'b01:   pc_load_val_c = alu_out;
            2'b10:   pc_load_val_c = jump_target_c;
            default: pc_load_val_c = pc_q;
        endcase
    end

    // Next-state, PC/IR update and completion pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pc_load_en_c) begin
                    pc_d = pc_load_val_c;
                end
                if (fetch_start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (MEM_LATENCY <= 1) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                ir_d    = mem_rdata;
                pc_d    = pc_inc_c;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any fetch in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
        end
    end

    // Status outputs decoded straight from the state register.
    assign mem_rd     = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign mem_addr   = pc_q;
    assign fetch_done = done_q;
    assign fsm_state  = state_q;

    // Architectural state and instruction field decode.
    assign pc       = pc_q;
    assign pc_plus4 = pc_inc_c;
    assign ir       = ir_q;
    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a fixed-latency memory model, a
// transaction-level PC/IR model and a monitor that checks every mem_rd pulse
// and every fetch_done against queued expectations.
module tb_fetch_unit;

    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock, reset;
    logic        fetch_start, pc_write, pc_write_cond, zero;
    logic [1:0]  pc_source;
    logic [31:0] alu_result, alu_out, mem_rdata;
    logic [31:0] mem_addr, pc, pc_plus4, ir;
    logic        mem_rd, busy, fetch_done;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [1:0]  fsm_state;

    fetch_unit #(.DATA_W(DW), .MEM_LATENCY(LAT), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .fetch_start(fetch_start),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero(zero),
        .pc_source(pc_source), .alu_result(alu_result), .alu_out(alu_out),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .busy(busy), .fetch_done(fetch_done), .pc(pc), .pc_plus4(pc_plus4),
        .ir(ir), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .fsm_state(fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] m_pc, m_ir;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C22_0004;
            32'h1000_0000: return 32'h0800_0010;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Memory: data is valid only in the cycle LAT cycles after the REQ cycle.
    int unsigned mcnt = 0;
    logic [31:0] maddr = '0;
    initial mem_rdata = '0;
    always begin
        @(posedge clock);
        #1;
        if (mcnt > 0) begin
            mcnt--;
            mem_rdata = (mcnt == 0) ? mem_word(maddr) : $urandom();
        end else begin
            mem_rdata = $urandom();
        end
        if (mem_rd === 1'b1) begin
            mcnt  = LAT;
            maddr = mem_addr;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a read or a completion.
    int unsigned rd_cyc = 0;
    exp_t        mon_e;
    logic [31:0] mon_a;
    logic [31:0] mon_nx;
    always begin
        @(posedge clock);
        #1;
        if (reset !== 1'b1) begin
            if (mem_rd === 1'b1) begin
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_rd_unexpected: got pulse at %h expected none", mem_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    chk("mem_addr", mem_addr, mon_a);
                end
                chk("busy_in_req", 32'(busy), 32'd1);
                rd_cyc = cyc;
            end
            if (fetch_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_done_unexpected: got pulse with ir=%h expected none", ir);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_nx = mon_e.pc + 32'd4;
                    chk("ir",       ir,            mon_e.ir);
                    chk("pc",       pc,            mon_e.pc);
                    chk("pc_plus4", pc_plus4,      mon_nx);
                    chk("opcode",   32'(opcode),   32'(mon_e.ir[31:26]));
                    chk("rs",       32'(rs),       32'(mon_e.ir[25:21]));
                    chk("rt",       32'(rt),       32'(mon_e.ir[20:16]));
                    chk("rd",       32'(rd),       32'(mon_e.ir[15:11]));
                    chk("shamt",    32'(shamt),    32'(mon_e.ir[10:6]));
                    chk("funct",    32'(funct),    32'(mon_e.ir[5:0]));
                    chk("imm",      32'(imm),      32'(mon_e.ir[15:0]));
                    chk("latency",  cyc - rd_cyc,  LAT + 1);
                    chk("done_idle_state", 32'(fsm_state), 32'd0);
                    chk("done_not_busy",   32'(busy),      32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_fetch();
        exp_t e;
        addr_q.push_back(m_pc);
        m_ir = mem_word(m_pc);
        m_pc = m_pc + 32'd4;
        e.ir = m_ir;
        e.pc = m_pc;
        exp_q.push_back(e);
    endtask

    task automatic model_load(input logic pw, input logic pwc, input logic z,
                              input logic [1:0] src, input logic [31:0] ar,
                              input logic [31:0] ao);
        if (pw || (pwc && z)) begin
            case (src)
                2'b00:   m_pc = ar;
                2'b01:   m_pc = ao;
                2'b10:   m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
                default: m_pc = m_pc;
            endcase
        end
    endtask

    task automatic clear_inputs();
        fetch_start   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        zero          = 1'b0;
        pc_source     = 2'b00;
        alu_result    = '0;
        alu_out       = '0;
    endtask

    // One IDLE-cycle command: optional PC load and optional fetch request.
    task automatic cmd(input logic pw, input logic pwc, input logic z,
                       input logic [1:0] src, input logic [31:0] ar,
                       input logic [31:0] ao, input logic fs);
        pc_write      = pw;
        pc_write_cond = pwc;
        zero          = z;
        pc_source     = src;
        alu_result    = ar;
        alu_out       = ao;
        fetch_start   = fs;
        model_load(pw, pwc, z, src, ar, ao);
        if (fs) model_fetch();
        step();
        clear_inputs();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) return;
            step();
        end
        total++;
        bad++;
        $display("FAIL wait_idle: busy=%b after 40 cycles expected 0", busy);
    endtask

    // fetch_start held for n cycles from IDLE: one fetch every LAT+2 cycles.
    task automatic hold_fetch(input int n);
        int k;
        k = (n + LAT + 1) / (LAT + 2);
        fetch_start = 1'b1;
        repeat (k) model_fetch();
        repeat (n) step();
        fetch_start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        m_pc = RPC;
        m_ir = '0;
        repeat (3) step();
        chk("rst_pc",        pc,                RPC);
        chk("rst_ir",        ir,                32'h0);
        chk("rst_state",     32'(fsm_state),    32'd0);
        chk("rst_mem_rd",    32'(mem_rd),       32'd0);
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_done",      32'(fetch_done),   32'd0);
        chk("rst_mem_addr",  mem_addr,          RPC);
        reset = 1'b0;
        step();

        // First fetch from address 0.
        cmd(0, 0, 0, 2'b00, 0, 0, 1);
        wait_idle();
        chk("t1_ir",     ir,           32'h8C22_0004);
        chk("t1_opcode", 32'(opcode),  32'h23);
        chk("t1_rs",     32'(rs),      32'd1);
        chk("t1_rt",     32'(rt),      32'd2);
        chk("t1_imm",    32'(imm),     32'h4);
        chk("t1_pc",     pc,           32'h4);

        // Held fetch_start: 4 cycles gives one fetch, 5 gives two.
        hold_fetch(4);
        hold_fetch(5);

        // Conditional branch.
        cmd(1, 0, 0, 2'b00, 32'h8, 0, 0);
        chk("br_setup_pc", pc, 32'h8);
        cmd(0, 1, 0, 2'b01, 0, 32'h40, 0);
        chk("br_notaken_pc", pc, 32'h8);
        cmd(0, 1, 1, 2'b01, 0, 32'h40, 0);
        chk("br_taken_pc", pc, 32'h40);

        // Jump after fetching a J instruction.
        cmd(1, 0, 0, 2'b00, 32'h1000_0000, 0, 1);
        wait_idle();
        chk("j_ir", ir, 32'h0800_0010);
        chk("j_pc_before", pc, 32'h1000_0004);
        cmd(1, 0, 0, 2'b10, 0, 0, 0);
        chk("j_pc", pc, 32'h1000_0040);

        // Same jump request while busy is ignored.
        cmd(0, 0, 0, 2'b00, 0, 0, 1);
        pc_write  = 1'b1;
        pc_source = 2'b10;
        step();
        step();
        clear_inputs();
        wait_idle();
        chk("busy_load_ignored", pc, 32'h1000_0044);

        // Source 11 holds the PC.
        cmd(1, 0, 0, 2'b11, $urandom(), $urandom(), 0);
        chk("src11_hold", pc, 32'h1000_0044);

        // Load and fetch in the same cycle, then PC wraps past the top.
        cmd(1, 0, 0, 2'b00, 32'hFFFF_FFFC, 0, 1);
        wait_idle();
        chk("wrap_pc",       pc,       32'h0);
        chk("wrap_pc_plus4", pc_plus4, 32'h4);

        // Reset asserted in WAIT aborts the fetch.
        cmd(0, 0, 0, 2'b00, 0, 0, 1);
        step();
        chk("in_wait", 32'(fsm_state), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        addr_q.delete();
        m_pc = RPC;
        m_ir = '0;
        chk("arst_pc",    pc,              RPC);
        chk("arst_ir",    ir,              32'h0);
        chk("arst_state", 32'(fsm_state),  32'd0);
        chk("arst_busy",  32'(busy),       32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("late_data_ir",   ir,               32'h0);
            chk("late_data_done", 32'(fetch_done),  32'd0);
        end

        // Randomized mix of fetches, PC loads and held requests.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    cmd(0, 0, 0, 2'b00, 0, 0, 1);
                    wait_idle();
                end
                1: begin
                    cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        $urandom(), $urandom(), 0);
                    chk("rnd_load_pc", pc, m_pc);
                end
                2: begin
                    cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        $urandom(), $urandom(), 1);
                    wait_idle();
                    chk("rnd_fetch_pc", pc, m_pc);
                end
                default: begin
                    hold_fetch($urandom_range(1, 10));
                    chk("rnd_hold_pc", pc, m_pc);
                end
            endcase
        end

        repeat (3) step();
        chk("sb_fetch_drain", 32'(exp_q.size()),  32'd0);
        chk("sb_addr_drain",  32'(addr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
